// File: rtl/opb_status_bank_if.sv
// OPB slave-side bus bundle for opb_status_bank; bit 0 is the MSB on every OPB vector.
`default_nettype none

interface opb_status_bank_if #(
  parameter int C_OPB_AWIDTH = 32,
  parameter int C_OPB_DWIDTH = 32
);
  logic [0:C_OPB_AWIDTH-1]   OPB_ABus;
  logic [0:C_OPB_DWIDTH/8-1] OPB_BE;
  logic [0:C_OPB_DWIDTH-1]   OPB_DBus;
  logic                      OPB_RNW;
  logic                      OPB_select;
  logic                      OPB_seqAddr;
  logic [0:C_OPB_DWIDTH-1]   Sl_DBus;
  logic                      Sl_xferAck;
  logic                      Sl_errAck;
  logic                      Sl_retry;
  logic                      Sl_toutSup;

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );
endinterface

`default_nettype wire

// File: rtl/opb_status_bank.sv
// Multi-channel live/sticky status bank with an atomic shadow snapshot, read over OPB.
`default_nettype none

module opb_status_bank #(
  parameter logic [31:0] C_BASEADDR    = 32'h01120100,
  parameter logic [31:0] C_HIGHADDR    = 32'h011201FF,
  parameter int          C_OPB_AWIDTH  = 32,
  parameter int          C_OPB_DWIDTH  = 32,
  parameter int          C_NUM_CH      = 4,
  parameter int          C_DATA_WIDTH  = 32,
  parameter logic [31:0] C_STICKY_MASK = 32'h0
) (
  input  wire logic                             OPB_Clk,
  input  wire logic                             OPB_Rst_n,
  opb_status_bank_if.slave                      opb,
  input  wire logic [C_NUM_CH*C_DATA_WIDTH-1:0] user_data_in,
  input  wire logic [C_NUM_CH-1:0]              user_valid,
  output logic                                  snap_pulse
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic rst_meta, rst_n_sync;
  logic [31:0] addr, offset, wdata, be_mask, wmasked, rd_word, rdata;
  logic [29:0] word;
  logic        in_range, commit, wr, is_ctrl, snap_req, clr_req;
  logic [C_NUM_CH-1:0]     ch_hit;
  logic [15:0]             snap_cnt;
  logic [C_DATA_WIDTH-1:0] live     [C_NUM_CH];
  logic [C_DATA_WIDTH-1:0] shadow   [C_NUM_CH];
  logic [C_DATA_WIDTH-1:0] clr_mask [C_NUM_CH];
  logic                    unused_bits;

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      rst_meta   <= 1'b0;
      rst_n_sync <= 1'b0;
    end else begin
      rst_meta   <= 1'b1;
      rst_n_sync <= rst_meta;
    end
  end

  assign addr     = opb.OPB_ABus;
  assign wdata    = opb.OPB_DBus;
  assign be_mask  = {{8{opb.OPB_BE[0]}}, {8{opb.OPB_BE[1]}},
                     {8{opb.OPB_BE[2]}}, {8{opb.OPB_BE[3]}}};
  assign wmasked  = wdata & be_mask;
  assign offset   = addr - C_BASEADDR;
  assign word     = offset[31:2];
  assign in_range = opb.OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
  assign commit   = (state == ST_IDLE) && in_range;
  assign wr       = commit && !opb.OPB_RNW;
  assign is_ctrl  = (word == 30'd0);
  assign snap_req = wr && is_ctrl && wmasked[0];
  assign clr_req  = wr && is_ctrl && wmasked[1];

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < C_NUM_CH; k++) begin
      ch_hit[k]   = (word == 30'(k + 1));
      clr_mask[k] = '0;
      if (wr && ch_hit[k])
        clr_mask[k] = wmasked[C_DATA_WIDTH-1:0];
      if (clr_req)
        clr_mask[k] = '1;
    end
    if (is_ctrl)
      rd_word = {snap_cnt, 8'(C_NUM_CH), 8'(C_DATA_WIDTH)};
    for (int k = 0; k < C_NUM_CH; k++) begin
      if (ch_hit[k])
        rd_word[C_DATA_WIDTH-1:0] = shadow[k];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_range) state_nxt = ST_ACK;
      ST_ACK:  state_nxt = ST_GAP;
      ST_GAP:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge OPB_Clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      state <= ST_IDLE;
      rdata <= '0;
    end else begin
      state <= state_nxt;
      if (commit)
        rdata <= opb.OPB_RNW ? rd_word : '0;
    end
  end

  // Shadow copies the pre-edge live values, so same-edge updates/clears land only in live.
  always_ff @(posedge OPB_Clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      snap_cnt   <= '0;
      snap_pulse <= 1'b0;
      for (int k = 0; k < C_NUM_CH; k++) begin
        live[k]   <= '0;
        shadow[k] <= '0;
      end
    end else begin
      snap_pulse <= snap_req;
      if (snap_req)
        snap_cnt <= snap_cnt + 16'd1;
      for (int k = 0; k < C_NUM_CH; k++) begin
        if (C_STICKY_MASK[k])
          live[k] <= (live[k] & ~clr_mask[k]) |
                     (user_valid[k] ? user_data_in[k*C_DATA_WIDTH +: C_DATA_WIDTH] : '0);
        else if (user_valid[k])
          live[k] <= user_data_in[k*C_DATA_WIDTH +: C_DATA_WIDTH];
        if (snap_req)
          shadow[k] <= live[k];
      end
    end
  end

  assign opb.Sl_DBus    = (state == ST_ACK) ? rdata : '0;
  assign opb.Sl_xferAck = (state == ST_ACK);
  assign opb.Sl_errAck  = 1'b0;
  assign opb.Sl_retry   = 1'b0;
  assign opb.Sl_toutSup = 1'b0;

  assign unused_bits = &{1'b0, opb.OPB_seqAddr, offset[1:0], wmasked};

endmodule

`default_nettype wire

// File: tb/tb_opb_status_bank.sv
// Directed self-checking bench for opb_status_bank (4 channels x 32 bits, channel 1 sticky).
`default_nettype none

module tb_opb_status_bank;

  localparam logic [31:0] BASE = 32'h01120100;
  localparam logic [31:0] HIGH = 32'h011201FF;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] udata = '0;
  logic [3:0]   uvalid = '0;
  logic         snap_pulse;
  int           checks = 0;
  int           errors = 0;
  int           pulses = 0;
  int           p0;
  logic [31:0]  rdv;
  bit           ack;

  always #5 clk = ~clk;

  opb_status_bank_if bus ();

  opb_status_bank #(.C_STICKY_MASK(32'h2)) dut (
    .OPB_Clk      (clk),
    .OPB_Rst_n    (rst_n),
    .opb          (bus),
    .user_data_in (udata),
    .user_valid   (uvalid),
    .snap_pulse   (snap_pulse)
  );

  always @(posedge clk) if (snap_pulse) pulses <= pulses + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One OPB transfer; optionally pulses user_valid on a channel at the commit edge.
  task automatic xfer(input logic [31:0] addr, input logic rnw, input logic [31:0] wd,
                      input logic [3:0] be, input bit exp_ack, input bit push_en,
                      input int push_ch, input logic [31:0] push_d, output logic [31:0] rd);
    bit acked;
    int lat;
    acked = 0; lat = 0; rd = '0;
    @(posedge clk); #1;
    bus.OPB_ABus = addr; bus.OPB_BE = be; bus.OPB_RNW = rnw;
    bus.OPB_DBus = rnw ? 32'h0 : wd; bus.OPB_select = 1'b1;
    if (push_en) begin
      udata[push_ch*32 +: 32] = push_d;
      uvalid[push_ch] = 1'b1;
    end
    for (int i = 1; i <= 4 && !acked; i++) begin
      @(negedge clk);
      if (i == 2) uvalid = '0;
      if (bus.Sl_xferAck) begin
        acked = 1; lat = i; rd = bus.Sl_DBus;
      end else begin
        check("dbus_zero_no_ack", bus.Sl_DBus, 32'h0);
      end
    end
    uvalid = '0;
    bus.OPB_select = 1'b0; bus.OPB_DBus = '0;
    check("ack_seen", 32'(acked), 32'(exp_ack));
    if (acked) begin
      check("ack_latency", lat, 2);
      @(negedge clk);
      check("ack_one_cycle", 32'(bus.Sl_xferAck), 32'h0);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] off, input logic [31:0] exp);
    logic [31:0] d;
    xfer(BASE + off, 1'b1, 32'h0, 4'hF, 1'b1, 1'b0, 0, 32'h0, d);
    check(tag, d, exp);
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] dummy;
    xfer(BASE + off, 1'b0, d, be, 1'b1, 1'b0, 0, 32'h0, dummy);
  endtask

  task automatic push(input int ch, input logic [31:0] d);
    @(posedge clk); #1;
    udata[ch*32 +: 32] = d; uvalid[ch] = 1'b1;
    @(posedge clk); #1;
    uvalid = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    bus.OPB_ABus = '0; bus.OPB_BE = '0; bus.OPB_DBus = '0;
    bus.OPB_RNW = 1'b0; bus.OPB_select = 1'b0; bus.OPB_seqAddr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", 32'(bus.Sl_xferAck), 32'h0);
    check("rst_dbus", bus.Sl_DBus, 32'h0);
    check("rst_pulse", 32'(snap_pulse), 32'h0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    rd_chk("ctrl_reset", 32'h00, 32'h00000420);

    // Non-sticky channel 0 keeps only the latest value
    push(0, 32'hA5); push(0, 32'h3C);
    p0 = pulses;
    wr(32'h00, 32'h1, 4'hF);
    rd_chk("ch0_live", 32'h04, 32'h3C);
    rd_chk("ctrl_cnt1", 32'h00, 32'h00010420);
    check("snap_pulse_once", pulses - p0, 1);

    // Sticky channel 1 accumulates, W1C clears
    push(1, 32'h01); push(1, 32'h10);
    wr(32'h00, 32'h1, 4'hF);
    rd_chk("ch1_sticky", 32'h08, 32'h11);
    wr(32'h08, 32'h01, 4'hF);
    wr(32'h00, 32'h1, 4'hF);
    rd_chk("ch1_w1c", 32'h08, 32'h10);

    // Snapshot bit outside enabled byte lane is ignored
    wr(32'h00, 32'h1, 4'b1110);
    rd_chk("ctrl_be_masked", 32'h00, 32'h00030420);

    // Non-sticky channel ignores writes
    wr(32'h04, 32'hFFFFFFFF, 4'hF);
    wr(32'h00, 32'h1, 4'hF);
    rd_chk("ch0_wr_ignored", 32'h04, 32'h3C);

    // Set wins over W1C in the same cycle
    xfer(BASE + 32'h08, 1'b0, 32'h10, 4'hF, 1'b1, 1'b1, 1, 32'h10, rdv);
    wr(32'h00, 32'h1, 4'hF);
    rd_chk("ch1_set_wins", 32'h08, 32'h10);

    // Snapshot + clear: shadow holds pre-clear value
    push(1, 32'hFF);
    wr(32'h00, 32'h3, 4'hF);
    rd_chk("ch1_snap_clr", 32'h08, 32'hFF);
    wr(32'h00, 32'h1, 4'hF);
    rd_chk("ch1_after_clr", 32'h08, 32'h00);
    rd_chk("ch0_clr_unaffected", 32'h04, 32'h3C);
    rd_chk("ctrl_cnt7", 32'h00, 32'h00070420);

    // Counter wrap, preloaded close to the top
    @(negedge clk);
    force dut.snap_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.snap_cnt;
    wr(32'h00, 32'h1, 4'hF);
    rd_chk("ctrl_cnt_ffff", 32'h00, 32'hFFFF0420);
    wr(32'h00, 32'h1, 4'hF);
    rd_chk("ctrl_cnt_wrap", 32'h00, 32'h00000420);

    // Address boundaries
    rd_chk("high_unmapped", HIGH - BASE, 32'h0);
    xfer(HIGH + 32'h4, 1'b1, 32'h0, 4'hF, 1'b0, 1'b0, 0, 32'h0, rdv);
    xfer(BASE - 32'h4, 1'b1, 32'h0, 4'hF, 1'b0, 1'b0, 0, 32'h0, rdv);

    // Reset asserted while the slave is acknowledging
    @(posedge clk); #1;
    bus.OPB_ABus = BASE; bus.OPB_BE = 4'hF; bus.OPB_RNW = 1'b1; bus.OPB_select = 1'b1;
    @(posedge clk); #2;
    check("pre_rst_ack", 32'(bus.Sl_xferAck), 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ack", 32'(bus.Sl_xferAck), 32'h0);
    check("rst_mid_dbus", bus.Sl_DBus, 32'h0);
    bus.OPB_select = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    rd_chk("post_rst_ctrl", 32'h00, 32'h00000420);
    rd_chk("post_rst_ch0", 32'h04, 32'h0);
    wr(32'h00, 32'h1, 4'hF);
    rd_chk("post_rst_live0", 32'h04, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
